// File: rtl/uart_word_tx.sv
// Serializes a latched 32-bit count word as four 8N1 UART frames on txd.
// Outputs are registered from the next-state values, so txd never has a combinational path to the pin.

module uart_word_tx #(
   parameter int CLKS_PER_BIT   = 434,
   parameter bit MSB_BYTE_FIRST = 1'b1,
   parameter int GAP_BITS       = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] send_f,
   input  logic        trans_ack,
   output logic        txd,
   output logic        busy,
   output logic        done
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0] GAP_LAST = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, DONE} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic [3:0]        gap_cnt, gap_cnt_n;
   logic [2:0]        bit_idx, bit_idx_n;
   logic [1:0]        byte_idx, byte_idx_n;
   logic [31:0]       shift_word, shift_word_n;
   logic              ack_q;
   logic              req;
   logic              tick;
   logic [1:0]        byte_sel;
   logic [7:0]        cur_byte;
   logic              txd_d, busy_d, done_d;

   assign req  = trans_ack & ~ack_q;
   assign tick = (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         shift_word <= '0;
         ack_q      <= 1'b0;
         txd        <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         gap_cnt    <= gap_cnt_n;
         bit_idx    <= bit_idx_n;
         byte_idx   <= byte_idx_n;
         shift_word <= shift_word_n;
         ack_q      <= trans_ack;
         txd        <= txd_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   // Each state holds for whole bit periods; the bit timer restarts on every state or bit change.
   always_comb begin
      state_n      = state;
      gap_cnt_n    = gap_cnt;
      bit_idx_n    = bit_idx;
      byte_idx_n   = byte_idx;
      shift_word_n = shift_word;
      case (state)
         IDLE: begin
            if (req) begin
               state_n      = START;
               shift_word_n = send_f;
            end
         end
         START: begin
            if (tick) begin
               state_n   = DATA;
               bit_idx_n = 3'd0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (tick) begin
               if (byte_idx == 2'd3) begin
                  state_n = DONE;
               end else begin
                  byte_idx_n = byte_idx + 2'd1;
                  if (GAP_BITS > 0) begin
                     state_n   = GAP;
                     gap_cnt_n = 4'd0;
                  end else begin
                     state_n = START;
                  end
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_cnt == GAP_LAST) state_n = START;
               else                     gap_cnt_n = gap_cnt + 4'd1;
            end
         end
         DONE: begin
            state_n    = IDLE;
            byte_idx_n = 2'd0;
         end
         default: state_n = IDLE;
      endcase

      if (tick || (state_n != state) || (state == IDLE)) bit_cnt_n = '0;
      else                                                bit_cnt_n = bit_cnt + 1'b1;
   end

   // The DONE cycle produces done=1/busy=0, which reach the pins on the following edge.
   always_comb begin
      byte_sel = MSB_BYTE_FIRST ? (2'd3 - byte_idx_n) : byte_idx_n;
      cur_byte = shift_word_n[{byte_sel, 3'b000} +: 8];
      txd_d    = 1'b1;
      case (state_n)
         START:   txd_d = 1'b0;
         DATA:    txd_d = cur_byte[bit_idx_n];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_n != IDLE);
      done_d = (state == DONE);
   end

endmodule
